// File: rtl/any1_pkg.sv
// any1_pkg: shared types, constants and helpers for the any1 branch predictor.
//   bp_ctr_t     2-bit saturating direction counter (00 strong-NT .. 11 strong-T)
//   BP_WNT       weak-not-taken; the value every entry holds after table init
//   BP_ST_*      predictor FSM state encodings
//   bp_sat()     saturating counter update for a resolved outcome
package any1_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_WNT = 2'b01;

  localparam logic [0:0] BP_ST_INIT = 1'b0;
  localparam logic [0:0] BP_ST_RUN  = 1'b1;

  // Taken moves toward 11 and not-taken toward 00; both ends hold.
  function automatic bp_ctr_t bp_sat(input bp_ctr_t ctr, input logic takb);
    bp_ctr_t r;
    r = ctr;
    if (takb) begin
      if (ctr != 2'b11) r = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) r = ctr - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/any1_bp_ram.sv
// any1_bp_ram: 2**IDXB x 2-bit counter table.
//   One write port and two synchronous read ports (a: prediction, b: update U1).
//   Reads are read-first: a read and a write to the same address in one cycle
//   return the old contents; the parent handles all forwarding.
// Ports
//   clk_i       clock
//   we_i        write enable
//   waddr_i     write address
//   wdata_i     write data
//   ra_addr_i   read port a address     ra_data_o  data, one cycle later
//   rb_addr_i   read port b address     rb_data_o  data, one cycle later
module any1_bp_ram
  import any1_pkg::*;
#(
  parameter int IDXB = 9
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IDXB-1:0] waddr_i,
  input  bp_ctr_t         wdata_i,
  input  logic [IDXB-1:0] ra_addr_i,
  output bp_ctr_t         ra_data_o,
  input  logic [IDXB-1:0] rb_addr_i,
  output bp_ctr_t         rb_data_o
);

  bp_ctr_t mem_q [0:(1<<IDXB)-1];
  bp_ctr_t ra_q;
  bp_ctr_t rb_q;

  // Table contents are not reset; the parent's INIT sweep defines them.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    ra_q <= mem_q[ra_addr_i];
    rb_q <= mem_q[rb_addr_i];
  end

  assign ra_data_o = ra_q;
  assign rb_data_o = rb_q;

endmodule

// File: rtl/any1_branch_predictor.sv
// any1_branch_predictor: gshare direction predictor with 2-bit counters.
//   After reset the table is swept to weak-not-taken (busy_o high), then the
//   predictor answers fetch lookups with one cycle of latency and trains on
//   resolved branches through a two-stage read/modify/write update pipe.
//   Both request streams are valid-only: a request is taken on every clock
//   edge where its valid is high; there is no ready and no stall.
// Ports
//   rst_i        async reset, active-high
//   clk_i        clock
//   busy_o       table initialisation in progress (FSM in INIT)
//   prd_v_i      prediction request valid
//   prd_pc_i     fetch PC
//   prd_v_o      prediction valid, one cycle after prd_v_i
//   prd_takb_o   predicted taken
//   prd_hist_o   history used for this prediction
//   upd_v_i      resolved branch valid
//   upd_pc_i     branch PC
//   upd_hist_i   history captured with the prediction
//   upd_takb_i   actual outcome
module any1_branch_predictor
  import any1_pkg::*;
#(
  parameter int AWID  = 32,
  parameter int IDXB  = 9,
  parameter int HISTB = 8
) (
  input  logic             rst_i,
  input  logic             clk_i,
  output logic             busy_o,
  input  logic             prd_v_i,
  input  logic [AWID-1:0]  prd_pc_i,
  output logic             prd_v_o,
  output logic             prd_takb_o,
  output logic [HISTB-1:0] prd_hist_o,
  input  logic             upd_v_i,
  input  logic [AWID-1:0]  upd_pc_i,
  input  logic [HISTB-1:0] upd_hist_i,
  input  logic             upd_takb_i
);

  // FSM and history
  logic [0:0]       state_q, state_d;
  logic [IDXB-1:0]  init_idx_q, init_idx_d;
  logic [HISTB-1:0] ghr_q, ghr_d;
  logic             run;

  // Prediction pipe
  logic             prd_v_q, prd_v_d;
  logic [HISTB-1:0] prd_hist_q, prd_hist_d;
  logic             prd_fwd_q, prd_fwd_d;
  bp_ctr_t          prd_fwd_ctr_q, prd_fwd_ctr_d;
  logic [IDXB-1:0]  prd_idx;
  logic [IDXB-1:0]  ghr_ext;
  bp_ctr_t          prd_ctr;

  // Update pipe (U1 is the cycle upd_v_i is presented, U2 the write cycle)
  logic             u1_v;
  logic [IDXB-1:0]  u1_idx;
  logic [IDXB-1:0]  upd_hist_ext;
  logic             u2_v_q, u2_v_d;
  logic [IDXB-1:0]  u2_idx_q, u2_idx_d;
  logic             u2_takb_q, u2_takb_d;
  logic             u2_fwd_q, u2_fwd_d;
  bp_ctr_t          u2_fwd_ctr_q, u2_fwd_ctr_d;
  bp_ctr_t          u2_old;
  bp_ctr_t          u2_new;

  // RAM interface
  logic             ram_we;
  logic [IDXB-1:0]  ram_waddr;
  bp_ctr_t          ram_wdata;
  bp_ctr_t          ram_ra_data;
  bp_ctr_t          ram_rb_data;

  // PC bits outside the index field do not take part (aliasing is allowed).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{prd_pc_i[AWID-1:IDXB+2], prd_pc_i[1:0],
                            upd_pc_i[AWID-1:IDXB+2], upd_pc_i[1:0]};

  assign run = (state_q == BP_ST_RUN);

  // History is zero-extended into the index width before the XOR.
  always_comb begin
    ghr_ext                   = '0;
    ghr_ext[HISTB-1:0]        = ghr_q;
    upd_hist_ext              = '0;
    upd_hist_ext[HISTB-1:0]   = upd_hist_i;
  end

  assign prd_idx = prd_pc_i[IDXB+1:2] ^ ghr_ext;
  assign u1_idx  = upd_pc_i[IDXB+1:2] ^ upd_hist_ext;
  assign u1_v    = upd_v_i & run;

  // FSM: INIT sweeps every index once, ending on all-ones, then RUN forever.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == BP_ST_INIT) begin
      init_idx_d = init_idx_q + IDXB'(1);
      if (init_idx_q == {IDXB{1'b1}}) state_d = BP_ST_RUN;
    end
  end

  // U2: counter comes from the RAM unless the previous U2 wrote the same
  // entry while this one was being read (read-first RAM would miss it).
  assign u2_old = u2_fwd_q ? u2_fwd_ctr_q : ram_rb_data;
  assign u2_new = bp_sat(u2_old, u2_takb_q);

  // Prediction counter gets the same treatment against a same-cycle U2 write.
  assign prd_ctr = prd_fwd_q ? prd_fwd_ctr_q : ram_ra_data;

  always_comb begin
    prd_v_d       = prd_v_i & run;
    prd_hist_d    = prd_v_d ? ghr_q : '0;
    prd_fwd_d     = u2_v_q && (prd_idx == u2_idx_q);
    prd_fwd_ctr_d = u2_new;

    u2_v_d        = u1_v;
    u2_idx_d      = u1_idx;
    u2_takb_d     = upd_takb_i;
    u2_fwd_d      = u2_v_q && (u1_idx == u2_idx_q);
    u2_fwd_ctr_d  = u2_new;

    // History is trained only by resolved outcomes, in update order.
    ghr_d = ghr_q;
    if (u2_v_q) ghr_d = {ghr_q[HISTB-2:0], u2_takb_q};
  end

  // The write port is owned by the INIT sweep until RUN, then by U2.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = init_idx_q;
    ram_wdata = BP_WNT;
    if (!run) begin
      ram_we = 1'b1;
    end else if (u2_v_q) begin
      ram_we    = 1'b1;
      ram_waddr = u2_idx_q;
      ram_wdata = u2_new;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= BP_ST_INIT;
      init_idx_q    <= '0;
      ghr_q         <= '0;
      prd_v_q       <= 1'b0;
      prd_hist_q    <= '0;
      prd_fwd_q     <= 1'b0;
      prd_fwd_ctr_q <= BP_WNT;
      u2_v_q        <= 1'b0;
      u2_idx_q      <= '0;
      u2_takb_q     <= 1'b0;
      u2_fwd_q      <= 1'b0;
      u2_fwd_ctr_q  <= BP_WNT;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      ghr_q         <= ghr_d;
      prd_v_q       <= prd_v_d;
      prd_hist_q    <= prd_hist_d;
      prd_fwd_q     <= prd_fwd_d;
      prd_fwd_ctr_q <= prd_fwd_ctr_d;
      u2_v_q        <= u2_v_d;
      u2_idx_q      <= u2_idx_d;
      u2_takb_q     <= u2_takb_d;
      u2_fwd_q      <= u2_fwd_d;
      u2_fwd_ctr_q  <= u2_fwd_ctr_d;
    end
  end

  any1_bp_ram #(
    .IDXB (IDXB)
  ) u_ram (
    .clk_i     (clk_i),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .ra_addr_i (prd_idx),
    .ra_data_o (ram_ra_data),
    .rb_addr_i (u1_idx),
    .rb_data_o (ram_rb_data)
  );

  // Takb is gated by valid so it reads 0 from the moment reset hits.
  assign busy_o     = ~run;
  assign prd_v_o    = prd_v_q;
  assign prd_takb_o = prd_v_q & prd_ctr[1];
  assign prd_hist_o = prd_hist_q;

endmodule

// File: tb/tb_any1_branch_predictor.sv
// Directed bench for any1_branch_predictor with IDXB=4, HISTB=4
// (index = pc[5:2] ^ ghr). Per-cycle vectors carry the request inputs and
// the prediction expected one edge later; reset and INIT corner cases are
// written out as short sequences.
module tb_any1_branch_predictor;

  localparam int AWID  = 32;
  localparam int IDXB  = 4;
  localparam int HISTB = 4;
  localparam int NVEC  = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             busy;
  logic             prd_v_i;
  logic [AWID-1:0]  prd_pc_i;
  logic             prd_v_o;
  logic             prd_takb_o;
  logic [HISTB-1:0] prd_hist_o;
  logic             upd_v_i;
  logic [AWID-1:0]  upd_pc_i;
  logic [HISTB-1:0] upd_hist_i;
  logic             upd_takb_i;

  any1_branch_predictor #(
    .AWID  (AWID),
    .IDXB  (IDXB),
    .HISTB (HISTB)
  ) dut (
    .rst_i      (rst),
    .clk_i      (clk),
    .busy_o     (busy),
    .prd_v_i    (prd_v_i),
    .prd_pc_i   (prd_pc_i),
    .prd_v_o    (prd_v_o),
    .prd_takb_o (prd_takb_o),
    .prd_hist_o (prd_hist_o),
    .upd_v_i    (upd_v_i),
    .upd_pc_i   (upd_pc_i),
    .upd_hist_i (upd_hist_i),
    .upd_takb_i (upd_takb_i)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic pv, input logic [AWID-1:0] ppc,
                       input logic uv, input logic [AWID-1:0] upc,
                       input logic [HISTB-1:0] uh, input logic ut);
    prd_v_i    = pv;
    prd_pc_i   = ppc;
    upd_v_i    = uv;
    upd_pc_i   = upc;
    upd_hist_i = uh;
    upd_takb_i = ut;
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // One clock edge, then settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops; bounded so a stuck FSM still reaches the report.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    check(name, n, 16);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             prd_v;
    logic [AWID-1:0]  prd_pc;
    logic             upd_v;
    logic [AWID-1:0]  upd_pc;
    logic             upd_takb;
    logic             exp_v;
    logic             exp_takb;
    logic [HISTB-1:0] exp_hist;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic pv, input logic [AWID-1:0] ppc,
                              input logic uv, input logic [AWID-1:0] upc, input logic ut,
                              input logic ev, input logic et, input logic [HISTB-1:0] eh);
    vec_t v;
    v.prd_v = pv; v.prd_pc = ppc; v.upd_v = uv; v.upd_pc = upc; v.upd_takb = ut;
    v.exp_v = ev; v.exp_takb = et; v.exp_hist = eh;
    return v;
  endfunction

  // Updates all use upd_hist=0, so update index = pc[5:2].
  // Comments give ghr during the cycle and the table entries touched.
  task automatic fill_vectors();
    vecs[0]  = mk(1, 32'h100, 0, 0, 0,        1, 0, 4'h0); // ghr 0, idx0 = 01
    vecs[1]  = mk(1, 32'h3C4, 0, 0, 0,        1, 0, 4'h0); // idx1 = 01
    vecs[2]  = mk(0, 0, 1, 32'h100, 1,        0, 0, 4'h0); // train idx0 taken
    vecs[3]  = mk(0, 0, 0, 0, 0,              0, 0, 4'h0); // U2: idx0 -> 10, ghr -> 0001
    vecs[4]  = mk(1, 32'h104, 0, 0, 0,        1, 1, 4'h1); // 1^1 = idx0 -> taken
    vecs[5]  = mk(0, 0, 1, 32'h100, 1,        0, 0, 4'h0); // idx0 10 -> 11
    vecs[6]  = mk(0, 0, 1, 32'h100, 1,        0, 0, 4'h0); // stays 11, ghr 0011
    vecs[7]  = mk(0, 0, 1, 32'h100, 1,        0, 0, 4'h0); // ghr 0111
    vecs[8]  = mk(0, 0, 1, 32'h100, 0,        0, 0, 4'h0); // ghr 1111, idx0 -> 10
    vecs[9]  = mk(0, 0, 0, 0, 0,              0, 0, 4'h0); // ghr -> 1110
    vecs[10] = mk(1, 32'h38, 0, 0, 0,         1, 1, 4'hE); // E^E = idx0 = 10
    vecs[11] = mk(0, 0, 1, 32'h14, 1,         0, 0, 4'h0); // idx5 01 -> 10
    vecs[12] = mk(0, 0, 1, 32'h14, 1,         0, 0, 4'h0); // back-to-back -> 11
    vecs[13] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0);
    vecs[14] = mk(0, 0, 1, 32'h14, 0,         0, 0, 4'h0); // idx5 11 -> 10
    vecs[15] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0); // ghr -> 0110
    vecs[16] = mk(1, 32'h0C, 0, 0, 0,         1, 1, 4'h6); // 3^6 = idx5 = 10
    vecs[17] = mk(0, 0, 1, 32'h24, 0,         0, 0, 4'h0); // idx9 01 -> 00
    vecs[18] = mk(0, 0, 1, 32'h24, 0,         0, 0, 4'h0); // stays 00
    vecs[19] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0);
    vecs[20] = mk(0, 0, 1, 32'h24, 1,         0, 0, 4'h0); // idx9 00 -> 01
    vecs[21] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0); // ghr -> 0001
    vecs[22] = mk(1, 32'h20, 0, 0, 0,         1, 0, 4'h1); // 8^1 = idx9 = 01
    vecs[23] = mk(0, 0, 1, 32'h30, 1,         0, 0, 4'h0); // U1 idx12
    vecs[24] = mk(1, 32'h34, 0, 0, 0,         1, 1, 4'h1); // D^1 = idx12 while U2 writes 10
    vecs[25] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0); // ghr now 0011
    vecs[26] = mk(0, 0, 1, 32'h08, 0,         0, 0, 4'h0); // idx2 -> 00, ghr 0110
    vecs[27] = mk(0, 0, 1, 32'h08, 1,         0, 0, 4'h0); // -> 01, ghr 1101
    vecs[28] = mk(0, 0, 1, 32'h08, 1,         0, 0, 4'h0); // -> 10, ghr 1011
    vecs[29] = mk(0, 0, 1, 32'h08, 1,         0, 0, 4'h0); // -> 11, ghr 0111
    vecs[30] = mk(0, 0, 0, 0, 0,              0, 0, 4'h0);
    vecs[31] = mk(1, 32'h100, 0, 0, 0,        1, 0, 4'h7); // 0^7 = idx7 = 01
    vecs[32] = mk(1, 32'h14, 0, 0, 0,         1, 1, 4'h7); // 5^7 = idx2 = 11
    vecs[33] = mk(1, 32'hFFFF_FF14, 0, 0, 0,  1, 1, 4'h7); // high PC bits alias to idx2
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    fill_vectors();
    repeat (2) tick();

    check("reset_busy", busy, 1);
    check("reset_prd_v", prd_v_o, 0);
    check("reset_takb", prd_takb_o, 0);
    check("reset_hist", prd_hist_o, 0);

    // INIT with both streams asserted: everything must be ignored.
    drive(1'b1, 32'h100, 1'b1, 32'h100, '0, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("init_busy_%0d", k), busy, 1);
      check($sformatf("init_prd_v_%0d", k), prd_v_o, 0);
      tick();
    end
    check("init_done_busy", busy, 0);
    check("init_done_prd_v", prd_v_o, 0);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].prd_v, vecs[i].prd_pc, vecs[i].upd_v, vecs[i].upd_pc, '0, vecs[i].upd_takb);
      tick();
      check($sformatf("vec%0d_prd_v", i), prd_v_o, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_takb", i), prd_takb_o, vecs[i].exp_takb);
        check($sformatf("vec%0d_hist", i), prd_hist_o, vecs[i].exp_hist);
      end
    end
    check("run_busy", busy, 0);

    // Reset with a prediction on the outputs and an update in flight.
    drive(1'b1, 32'h100, 1'b1, 32'h100, '0, 1'b1);
    tick();
    check("inflight_prd_v", prd_v_o, 1);
    check("inflight_hist", prd_hist_o, 4'h7);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_prd_v", prd_v_o, 0);
    check("midrun_rst_takb", prd_takb_o, 0);
    check("midrun_rst_hist", prd_hist_o, 0);
    check("midrun_rst_busy", busy, 1);
    tick();
    rst = 1'b0;

    // Reset partway through INIT; the sweep must start over.
    repeat (5) tick();
    check("midinit_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midinit_rst_busy", busy, 1);
    check("midinit_rst_prd_v", prd_v_o, 0);
    tick();
    rst = 1'b0;
    count_busy("reinit_busy_cycles");

    // Table and history are fresh: idx0 (was 10) and idx2 (was 11) read 01.
    drive(1'b1, 32'h100, 1'b0, '0, '0, 1'b0);
    tick();
    check("post_rst_idx0_v", prd_v_o, 1);
    check("post_rst_idx0_takb", prd_takb_o, 0);
    check("post_rst_idx0_hist", prd_hist_o, 0);
    drive(1'b1, 32'h08, 1'b0, '0, '0, 1'b0);
    tick();
    check("post_rst_idx2_v", prd_v_o, 1);
    check("post_rst_idx2_takb", prd_takb_o, 0);
    idle_inputs();
    tick();
    check("post_rst_idle_v", prd_v_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the sequence above is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
